// File: rtl/wormux_pkg.sv
// wormux_pkg: shared definitions for the wired-OR word mux arbiter.
// Holds the grant state encodings plus the round-robin pick and
// one-hot-to-index helpers used by wormux_arb.
package wormux_pkg;

    // Widest source count the helper functions can handle.
    localparam int MAX_DEPTH = 64;
    localparam int MAX_IDX_W = 6;

    // Grant state; derived from the en register, never stored separately.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // One-hot pick of the first set request after position ptr, wrapping at depth.
    // The source at ptr itself is considered last, so it only wins when it is alone.
    function automatic logic [MAX_DEPTH-1:0] rr_pick(
        input logic [MAX_DEPTH-1:0] req,
        input int                   depth,
        input int                   ptr
    );
        logic [MAX_DEPTH-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (k <= depth) begin
                idx = ptr + k;
                if (idx >= depth) begin
                    idx = idx - depth;
                end
                if (!found && req[idx[MAX_IDX_W-1:0]]) begin
                    pick[idx[MAX_IDX_W-1:0]] = 1'b1;
                    found                    = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    // Index of the set bit of a one-hot vector (0 for an all-zero vector).
    function automatic int onehot_idx(input logic [MAX_DEPTH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wormux_onehot_or.sv
// wormux_onehot_or: WIDTH x DEPTH wired-OR word mux.
// Each slice is gated by its enable bit before the OR, so slices whose
// enable is low never reach the output; en == 0 yields an all-zero word.
module wormux_onehot_or
    import wormux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic [DEPTH-1:0]       en,
    input  logic [WIDTH*DEPTH-1:0] mux_in,
    output logic [WIDTH-1:0]       out_data
);

    // AND-gate every slice with its enable and OR the results together.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out_data = out_data | (mux_in[WIDTH*i +: WIDTH] & {WIDTH{en[i]}});
        end
    end

endmodule

// File: rtl/wormux_arb.sv
// wormux_arb: round-robin arbiter driving a one-hot enable onto a wired-OR
// word mux, with a valid/ready output handshake and per-source ack pulses.
// Optional feature macro: WORMUX_ARB_LOCK_EN adds the lock port and a burst
// counter that lets a locked source keep the grant for up to MAX_BURST words.
module wormux_arb
    import wormux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 10,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DEPTH-1:0]       req,
    input  logic [WIDTH*DEPTH-1:0] mux_in,
`ifdef WORMUX_ARB_LOCK_EN
    input  logic [DEPTH-1:0]       lock,
`endif
    output logic [DEPTH-1:0]       ack,
    output logic [DEPTH-1:0]       en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [DEPTH-1:0]   en_nxt;
    logic [DEPTH-1:0]   pick_from_ptr;
    logic [DEPTH-1:0]   pick_from_g;
    logic [PTR_W-1:0]   g_ptr;
    int                 g;
    logic               granted_req;
    logic               hs;

`ifdef WORMUX_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               hold_burst;
`else
    // Burst length only matters when locking is compiled in.
    localparam int unused_max_burst = MAX_BURST;
`endif

    // Grant state, handshake and output decode, all from the registered en.
    always_comb begin
        state       = (|en) ? ST_XFER : ST_IDLE;
        g           = onehot_idx(MAX_DEPTH'(en));
        g_ptr       = PTR_W'(g);
        granted_req = |(en & req);
        out_valid   = granted_req;
        hs          = granted_req && out_ready;
        ack         = hs ? en : '0;
    end

    // Candidate grants: rotate from the stored pointer, or from the current grant.
    always_comb begin
        pick_from_ptr = DEPTH'(rr_pick(MAX_DEPTH'(req), DEPTH, int'(ptr)));
        pick_from_g   = DEPTH'(rr_pick(MAX_DEPTH'(req), DEPTH, g));
    end

`ifdef WORMUX_ARB_LOCK_EN
    // A locked source keeps the grant while its burst has room left.
    always_comb begin
        hold_burst = (|(en & lock)) && ((int'(cnt) + 1) < MAX_BURST);
    end
`endif

    // Next grant, pointer and burst count.
    always_comb begin
        en_nxt  = en;
        ptr_nxt = ptr;
`ifdef WORMUX_ARB_LOCK_EN
        cnt_nxt = cnt;
`endif
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    en_nxt = pick_from_ptr;
                end
            end
            ST_XFER: begin
                if (hs) begin
                    ptr_nxt = g_ptr;
`ifdef WORMUX_ARB_LOCK_EN
                    if (hold_burst) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                        en_nxt  = pick_from_g;
                    end
`else
                    en_nxt  = pick_from_g;
`endif
                end else if (!granted_req) begin
                    // Granted source withdrew: re-arbitrate as if idle.
                    en_nxt  = pick_from_ptr;
`ifdef WORMUX_ARB_LOCK_EN
                    cnt_nxt = '0;
`endif
                end
            end
            default: begin
                en_nxt = '0;
            end
        endcase
    end

    // Grant, pointer and burst registers; reset drops any pending word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en  <= '0;
            ptr <= PTR_W'(DEPTH - 1);
`ifdef WORMUX_ARB_LOCK_EN
            cnt <= '0;
`endif
        end else begin
            en  <= en_nxt;
            ptr <= ptr_nxt;
`ifdef WORMUX_ARB_LOCK_EN
            cnt <= cnt_nxt;
`endif
        end
    end

    wormux_onehot_or #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_or (
        .en       (en),
        .mux_in   (mux_in),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_wormux_arb.sv
// tb_wormux_arb: self-checking bench for wormux_arb (default build; the lock
// scenario is compiled when WORMUX_ARB_LOCK_EN is defined).
module tb_wormux_arb;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 10;
    localparam int MAX_BURST = 4;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [DEPTH-1:0]       req;
    logic [WIDTH*DEPTH-1:0] mux_in;
`ifdef WORMUX_ARB_LOCK_EN
    logic [DEPTH-1:0]       lock;
`endif
    logic [DEPTH-1:0]       ack;
    logic [DEPTH-1:0]       en;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    wormux_arb #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .mux_in    (mux_in),
`ifdef WORMUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_slices(input logic [WIDTH-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            mux_in[WIDTH*i +: WIDTH] = base + WIDTH'(i);
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
`ifdef WORMUX_ARB_LOCK_EN
        lock      = '0;
`endif
        step();
        step();
        resetn = 1'b1;
    endtask

    function automatic logic [DEPTH-1:0] onehot_of(input int idx);
        logic [DEPTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int scan_next(input logic [DEPTH-1:0] r, input int from);
        int j;
        for (int k = 1; k <= DEPTH; k++) begin
            j = (from + k) % DEPTH;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic test_reset();
        req       = 10'h3FF;
        out_ready = 1'b1;
        fill_slices(32'hA0);
        resetn    = 1'b0;
        @(negedge clk);
        chk_cnt++; if (en !== 10'h000) $display("FAIL reset_en got %h exp %h", en, 10'h000); else pass_cnt++;
        chk_cnt++; if (ack !== 10'h000) $display("FAIL reset_ack got %h exp %h", ack, 10'h000); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data got %h exp %h", out_data, 32'h0); else pass_cnt++;
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk_cnt++; if (en !== 10'h000) $display("FAIL release_en_before_edge got %h exp %h", en, 10'h000); else pass_cnt++;
        step();
        @(negedge clk);
        chk_cnt++; if (en !== 10'h001) $display("FAIL release_first_grant got %h exp %h", en, 10'h001); else pass_cnt++;
        // Asynchronous reset in the middle of a transfer clears the grant at once.
        resetn = 1'b0;
        #1;
        chk_cnt++; if (en !== 10'h000) $display("FAIL midreset_en got %h exp %h", en, 10'h000); else pass_cnt++;
        chk_cnt++; if (ack !== 10'h000) $display("FAIL midreset_ack got %h exp %h", ack, 10'h000); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midreset_valid got %b exp 0", out_valid); else pass_cnt++;
        step();
    endtask

    task automatic test_round_robin();
        int idx;
        do_reset();
        fill_slices(32'hA0);
        req       = 10'h3FF;
        out_ready = 1'b1;
        exp_q.delete();
        for (int n = 0; n < 12; n++) exp_q.push_back(n % DEPTH);
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                idx = exp_q.pop_front();
                chk_cnt++; if (out_data !== 32'hA0 + WIDTH'(idx)) $display("FAIL rr_data got %h exp %h", out_data, 32'hA0 + WIDTH'(idx)); else pass_cnt++;
                chk_cnt++; if (ack !== onehot_of(idx)) $display("FAIL rr_ack got %h exp %h", ack, onehot_of(idx)); else pass_cnt++;
                chk_cnt++; if (en !== onehot_of(idx)) $display("FAIL rr_en got %h exp %h", en, onehot_of(idx)); else pass_cnt++;
            end else begin
                chk_cnt++; if (ack !== 10'h000) $display("FAIL rr_idle_ack got %h exp %h", ack, 10'h000); else pass_cnt++;
            end
            step();
        end
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL rr_timeout remaining %0d exp 0", exp_q.size()); else pass_cnt++;
        req       = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        fill_slices(32'hB0);
        req       = 10'h010;
        out_ready = 1'b0;
        step();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk_cnt++; if (en !== 10'h010) $display("FAIL stall_en got %h exp %h", en, 10'h010); else pass_cnt++;
            chk_cnt++; if (out_data !== 32'hB4) $display("FAIL stall_data got %h exp %h", out_data, 32'hB4); else pass_cnt++;
            chk_cnt++; if (ack !== 10'h000) $display("FAIL stall_ack got %h exp %h", ack, 10'h000); else pass_cnt++;
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid got %b exp 1", out_valid); else pass_cnt++;
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (ack !== 10'h010) $display("FAIL stall_release_ack got %h exp %h", ack, 10'h010); else pass_cnt++;
        step();
        req       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_cnt++; if (ack !== 10'h000) $display("FAIL stall_single_pulse got %h exp %h", ack, 10'h000); else pass_cnt++;
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        fill_slices(32'hC0);
        req       = 10'h080;
        out_ready = 1'b0;
        step();
        @(negedge clk);
        chk_cnt++; if (en !== 10'h080) $display("FAIL wd_grant got %h exp %h", en, 10'h080); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL wd_valid_before got %b exp 1", out_valid); else pass_cnt++;
        step();
        req       = 10'h004;
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL wd_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (ack !== 10'h000) $display("FAIL wd_ack got %h exp %h", ack, 10'h000); else pass_cnt++;
        step();
        @(negedge clk);
        chk_cnt++; if (en !== 10'h004) $display("FAIL wd_regrant got %h exp %h", en, 10'h004); else pass_cnt++;
        chk_cnt++; if (ack !== 10'h004) $display("FAIL wd_regrant_ack got %h exp %h", ack, 10'h004); else pass_cnt++;
        chk_cnt++; if (out_data !== 32'hC2) $display("FAIL wd_regrant_data got %h exp %h", out_data, 32'hC2); else pass_cnt++;
        step();
        req       = '0;
        out_ready = 1'b0;
    endtask

`ifdef WORMUX_ARB_LOCK_EN
    task automatic test_lock();
        int idx;
        int seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        fill_slices(32'hD0);
        lock      = 10'h001;
        req       = 10'h003;
        out_ready = 1'b1;
        exp_q.delete();
        for (int n = 0; n < 10; n++) exp_q.push_back(seq[n]);
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                idx = exp_q.pop_front();
                chk_cnt++; if (en !== onehot_of(idx)) $display("FAIL lock_en got %h exp %h", en, onehot_of(idx)); else pass_cnt++;
                chk_cnt++; if (out_data !== 32'hD0 + WIDTH'(idx)) $display("FAIL lock_data got %h exp %h", out_data, 32'hD0 + WIDTH'(idx)); else pass_cnt++;
            end
            step();
        end
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL lock_timeout remaining %0d exp 0", exp_q.size()); else pass_cnt++;
        lock      = '0;
        req       = '0;
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] word [DEPTH];
        logic [DEPTH-1:0] last_ack;
        logic [DEPTH-1:0] exp_en;
        logic [DEPTH-1:0] exp_ack;
        logic [WIDTH-1:0] exp_data;
        logic             exp_valid;
        logic             exp_hs;
        int               m_idx;
        int               m_ptr;
        do_reset();
        m_idx    = -1;
        m_ptr    = DEPTH - 1;
        last_ack = '0;
        for (int i = 0; i < DEPTH; i++) word[i] = $urandom();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!req[i] || last_ack[i]) word[i] = $urandom();
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                mux_in[WIDTH*i +: WIDTH] = word[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_en    = (m_idx < 0) ? '0 : onehot_of(m_idx);
            exp_valid = (m_idx >= 0) && req[m_idx];
            exp_hs    = exp_valid && out_ready;
            exp_ack   = exp_hs ? exp_en : '0;
            exp_data  = (m_idx >= 0) ? word[m_idx] : '0;
            chk_cnt++; if ($countones(en) > 1) $display("FAIL rnd_onehot cyc %0d got %h exp popcount<=1", cyc, en); else pass_cnt++;
            chk_cnt++; if (en !== exp_en) $display("FAIL rnd_en cyc %0d got %h exp %h", cyc, en, exp_en); else pass_cnt++;
            chk_cnt++; if (out_valid !== exp_valid) $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, out_valid, exp_valid); else pass_cnt++;
            chk_cnt++; if (ack !== exp_ack) $display("FAIL rnd_ack cyc %0d got %h exp %h", cyc, ack, exp_ack); else pass_cnt++;
            chk_cnt++; if (out_data !== exp_data) $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, out_data, exp_data); else pass_cnt++;
            last_ack = exp_ack;
            if (m_idx < 0) begin
                m_idx = scan_next(req, m_ptr);
            end else if (exp_hs) begin
                m_ptr = m_idx;
                m_idx = scan_next(req, m_idx);
            end else if (!req[m_idx]) begin
                m_idx = scan_next(req, m_ptr);
            end
            step();
        end
        req       = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        mux_in    = '0;
`ifdef WORMUX_ARB_LOCK_EN
        lock      = '0;
`endif
        #2;
        test_reset();
        test_round_robin();
        test_stall();
        test_withdraw();
`ifdef WORMUX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, checks %0d passed %0d", chk_cnt, pass_cnt);
        $fatal(1, "watchdog");
    end

endmodule
